// File: rtl/split_stream_pkt_fifo.sv
// ---------------------------------------------------------------------------
// split_stream_pkt_fifo
//
// Packet-aware 1-to-N stream replicator. Every accepted input beat
// ({tuser,tdata} flattened into WIDTH bits) is pushed, together with its
// tlast, into a private FIFO for each output enabled for the current packet.
// The enable mask is only sampled on the first beat of a packet, so an output
// either sees a whole packet or none of it. A stalled output throttles the
// input only once its own FIFO is full.
//
// Parameters
//   WIDTH        beat width
//   NUM_OUTPUTS  number of outputs (1..4)
//   FIFO_SIZE    log2 of per-output FIFO depth (depth >= 2)
//
// Ports
//   clk          clock
//   reset        synchronous active-high reset (clears pkt_count too)
//   clear        synchronous flush of FIFOs, mask and packet state
//   enable_mask  requested outputs, sampled on the first beat of a packet
//   i_t*         input AXI-stream (tdata/tlast/tvalid/tready)
//   o_t*         per-output AXI-stream, output k at o_tdata[k*WIDTH +: WIDTH]
//   active_mask  mask latched for the packet in flight
//   pkt_count    accepted tlast beats, wraps at 2**32
// ---------------------------------------------------------------------------
// Packet FSM
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_SOP  | next accepted beat starts a packet; enable_mask is used
//   ST_BODY | inside a packet; the latched active_mask is used
// ---------------------------------------------------------------------------
module split_stream_pkt_fifo #(
    parameter int WIDTH       = 160,
    parameter int NUM_OUTPUTS = 2,
    parameter int FIFO_SIZE   = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic [NUM_OUTPUTS-1:0]       enable_mask,
    input  logic [WIDTH-1:0]             i_tdata,
    input  logic                         i_tlast,
    input  logic                         i_tvalid,
    output logic                         i_tready,
    output logic [NUM_OUTPUTS*WIDTH-1:0] o_tdata,
    output logic [NUM_OUTPUTS-1:0]       o_tlast,
    output logic [NUM_OUTPUTS-1:0]       o_tvalid,
    input  logic [NUM_OUTPUTS-1:0]       o_tready,
    output logic [NUM_OUTPUTS-1:0]       active_mask,
    output logic [31:0]                  pkt_count
);

    localparam int DEPTH = 2 ** FIFO_SIZE;
    // Occupancy value meaning "full": a one in the extra MSB of the counter.
    localparam logic [FIFO_SIZE:0] OCC_FULL = {1'b1, {FIFO_SIZE{1'b0}}};

    typedef enum logic {
        ST_SOP  = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic                     sop;
    logic                     accept;
    logic [NUM_OUTPUTS-1:0]   eff_mask;
    logic [NUM_OUTPUTS-1:0]   fifo_full;
    logic [NUM_OUTPUTS-1:0]   wr_en;
    logic [NUM_OUTPUTS-1:0]   active_mask_q;
    logic [31:0]              pkt_count_q;

    // -----------------------------------------------------------------------
    // Packet FSM: state register / next-state / outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q <= ST_SOP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = i_tlast ? ST_SOP : ST_BODY;
        end
    end

    always_comb begin
        sop = (state_q == ST_SOP);
    end

    // -----------------------------------------------------------------------
    // Mask selection and input handshake
    // -----------------------------------------------------------------------
    assign eff_mask = sop ? enable_mask : active_mask_q;

    // Only the outputs this beat will actually be written to may stall the
    // input. A read on a full FIFO in the same cycle is deliberately ignored
    // so i_tready has no combinational path from o_tready.
    always_comb begin
        i_tready = 1'b1;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (eff_mask[k] && fifo_full[k]) begin
                i_tready = 1'b0;
            end
        end
    end

    assign accept = i_tvalid && i_tready;

    // A beat accepted in a clear cycle is dropped.
    assign wr_en = (accept && !clear) ? eff_mask : '0;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            active_mask_q <= '0;
        end else if (accept && sop) begin
            active_mask_q <= enable_mask;
        end
    end

    assign active_mask = active_mask_q;

    // clear leaves the packet counter alone; only reset zeroes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count_q <= '0;
        end else if (!clear && accept && i_tlast) begin
            pkt_count_q <= pkt_count_q + 32'd1;
        end
    end

    assign pkt_count = pkt_count_q;

    // -----------------------------------------------------------------------
    // Per-output FIFOs. Only NUM_OUTPUTS instances are generated.
    // -----------------------------------------------------------------------
    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : gen_out
        logic [WIDTH:0]       mem [DEPTH];
        logic [FIFO_SIZE-1:0] wr_ptr;
        logic [FIFO_SIZE-1:0] rd_ptr;
        logic [FIFO_SIZE:0]   occ;
        logic                 wr;
        logic                 rd;

        assign wr = wr_en[k];
        assign rd = o_tvalid[k] && o_tready[k];

        always_ff @(posedge clk) begin
            if (reset || clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (wr) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({wr, rd})
                    2'b10:   occ <= occ + 1'b1;
                    2'b01:   occ <= occ - 1'b1;
                    default: occ <= occ;
                endcase
            end
        end

        // Storage needs no reset: occupancy decides what is visible.
        always_ff @(posedge clk) begin
            if (wr) begin
                mem[wr_ptr] <= {i_tlast, i_tdata};
            end
        end

        assign fifo_full[k]                = (occ == OCC_FULL);
        assign o_tvalid[k]                 = (occ != '0);
        // Head entry is read straight from storage, so it stays stable
        // while the output is stalled.
        assign o_tlast[k]                  = mem[rd_ptr][WIDTH];
        assign o_tdata[k*WIDTH +: WIDTH]   = mem[rd_ptr][WIDTH-1:0];
    end

endmodule
